mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory (M) pipeline stage, directly downstream of the Execute stage and upstream of Writeback.
- Latches the EM bus and waits for the data-SRAM response to any load or store Execute issued.
- Aligns and extends load data, then forwards results to Decode for bypass and stall.
- Hands a completed MW bus to Writeback through a valid/allowin handshake, and supports a pipeline flush from Writeback.

Parameters:
- EM_W, 193, EM bus width. Fields, MSB first: pc 32, rf_wdata 32, gr_we 1, dest 5, res_from_mem 4, mem_addr 32, ex 1, ecode 6, esubcode 1, csr_addr 14, csr_we 1, csr_wmask 32, csr_wdata 32.
- MW_W, 157, MW bus width. Fields, MSB first: pc 32, rf_wdata 32, gr_we 1, dest 5, ex 1, ecode 6, esubcode 1, csr_addr 14, csr_we 1, csr_wmask 32, csr_wdata 32.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- W_allowin  in  1  Writeback can accept
- M_allowin  out  1  M can accept from Execute
- EM_valid  in  1  Execute output valid
- EM_BUS  in  EM_W  Execute payload
- EM_mem_req  in  1  Execute issued a data-SRAM request (en=1) for this instruction
- flush  in  1  exception/ertn commit in Writeback; kill M contents
- data_sram_data_ok  in  1  response pulse for the oldest outstanding request
- data_sram_rdata  in  32  read data, valid with data_ok
- MW_valid  out  1  M output valid
- MW_BUS  out  MW_W  Writeback payload
- MD_for_BUS  out  38  {M_busy 1, dest 5, rf_wdata 32}

Behaviour:
- Reset (rstn=0 at posedge): M_valid=0, bus register=0, state=IDLE, rdata buffer=0, req flag=0.
- After reset: MW_valid=0, MD_for_BUS=0, M_allowin=1.
- Capture: when EM_valid && M_allowin, latch EM_BUS and EM_mem_req; M_valid<=EM_valid whenever M_allowin.
- M_allowin = !M_valid || (M_ready_go && W_allowin).
- MW_valid = M_valid && M_ready_go && !flush.
- flush at posedge: M_valid<=0. Capture is suppressed that cycle.
- M_ready_go = !req_M || data_ok this cycle (state WAIT) || state==HOLD.
- FSM states:
  - IDLE: no outstanding request. If an instruction with EM_mem_req is captured, go to WAIT.
  - WAIT: on data_ok && W_allowin && !flush, complete. Go to WAIT if a new req is captured the same cycle, else IDLE.
  - WAIT, data_ok && !W_allowin: buffer rdata, go to HOLD.
  - WAIT, flush without data_ok: go to DROP.
  - WAIT, flush with data_ok: go to IDLE.
  - HOLD: use buffered rdata. Leave when W_allowin (to IDLE, or WAIT if a new req is captured). On flush go to IDLE.
  - DROP: M_allowin=0 until data_ok, which is discarded; then go to IDLE. Prevents mis-attributing a stale response.
- Only one request is ever outstanding; M_allowin blocks further requests while WAIT/DROP is unresolved.
- data_ok in IDLE/HOLD is a protocol error; ignore it.
- Load data: res_from_mem [3]=word, [1]=half, [0]=byte, [2]=zero-extend (else sign-extend).
  - Byte select by mem_addr[1:0].
  - Half select by mem_addr[1]: 0 → bits 15:0, 1 → 31:16.
  - Word is unshifted.
  - rf_wdata_M = |res_from_mem ? extended load : bus rf_wdata.
- Stores: same wait on data_ok; data is ignored.
- If bus ex=1, mem_req is still honoured (Execute may have issued). The ex/ecode/esubcode fields pass through unchanged.
- MD_for_BUS:
  - dest field = dest & {5{M_valid && gr_we}}.
  - M_busy = M_valid && |res_from_mem && !M_ready_go; Decode stalls on a match.
  - rf_wdata = rf_wdata_M.
- MW_BUS is combinational from the registered bus plus the load result.

Test Plan:
- ALU op (no req), W_allowin=1 → MW_valid 1 cycle after capture, rf_wdata passes through, state stays IDLE.
- ld.b with addr 0x..03, rdata 0x80FF_FF7F, data_ok 2 cycles later → MW_valid on the data_ok cycle, rf_wdata 0xFFFFFF80. Same with ld.bu → 0x00000080.
- ld.h with addr[1]=1, rdata 0x8001_1234 → sign 0xFFFF8001, unsigned 0x00008001. M_busy=1 until data_ok; M_allowin=0 meanwhile.
- data_ok while W_allowin=0 → HOLD, buffered data appears when W_allowin rises 3 cycles later; a later rdata change has no effect.
- flush during WAIT → MW_valid stays 0. Next data_ok is dropped, M_allowin returns 1 the cycle after, and the next load gets its own data.
- Back-to-back loads with data_ok every cycle and W_allowin=1 → one completion per cycle, each with correct data.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and payload signals between Execute, the M stage, Writeback, Decode and the data SRAM.
// The slave modport is the M stage's view; master is the surrounding pipeline.
interface mem_stage_if #(
  parameter int EM_W = 193,
  parameter int MW_W = 157
);
  logic            W_allowin;
  logic            M_allowin;
  logic            EM_valid;
  logic [EM_W-1:0] EM_BUS;
  logic            EM_mem_req;
  logic            flush;
  logic            data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            MW_valid;
  logic [MW_W-1:0] MW_BUS;
  logic [37:0]     MD_for_BUS;

  modport slave (
    input  W_allowin, EM_valid, EM_BUS, EM_mem_req, flush,
           data_sram_data_ok, data_sram_rdata,
    output M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );

  modport master (
    output W_allowin, EM_valid, EM_BUS, EM_mem_req, flush,
           data_sram_data_ok, data_sram_rdata,
    input  M_allowin, MW_valid, MW_BUS, MD_for_BUS
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one EM instruction, waits for its data-SRAM response,
// aligns/extends load data and hands the result to Writeback and the Decode bypass.
module mem_stage #(
  parameter int EM_W = 193,
  parameter int MW_W = 157
) (
  input  logic        clk,
  input  logic        rstn,
  mem_stage_if.slave  bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rf_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic [31:0] mem_addr;
    logic        ex;
    logic [5:0]  ecode;
    logic        esubcode;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
  } em_bus_t;

  // DROP: a flushed request is still in flight; its response must be swallowed.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  em_bus_t         em_r;
  logic            m_valid;
  logic            req_m;
  state_t          state;
  logic [31:0]     rdata_buf;

  logic            data_ok;
  logic            ready_go;
  logic            m_allowin;
  logic            capture;
  logic            capture_req;
  logic [31:0]     rdata_src;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     load_val;
  logic [31:0]     rf_wdata_m;
  logic [MW_W-1:0] mw_bus;

  assign data_ok     = bus.data_sram_data_ok;
  assign ready_go    = !req_m || (state == S_WAIT && data_ok) || (state == S_HOLD);
  assign m_allowin   = (state != S_DROP) && (!m_valid || (ready_go && bus.W_allowin));
  assign capture     = m_allowin && !bus.flush;
  assign capture_req = capture && bus.EM_valid && bus.EM_mem_req;
  assign rdata_src   = (state == S_HOLD) ? rdata_buf : bus.data_sram_rdata;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_v   = rdata_src[7:0];
    half_v   = em_r.mem_addr[1] ? rdata_src[31:16] : rdata_src[15:0];
    load_val = rdata_src;
    case (em_r.mem_addr[1:0])
      2'd1:    byte_v = rdata_src[15:8];
      2'd2:    byte_v = rdata_src[23:16];
      2'd3:    byte_v = rdata_src[31:24];
      default: byte_v = rdata_src[7:0];
    endcase
    if (em_r.res_from_mem[3]) begin
      load_val = rdata_src;
    end else if (em_r.res_from_mem[1]) begin
      load_val = {{16{half_v[15] & ~em_r.res_from_mem[2]}}, half_v};
    end else begin
      load_val = {{24{byte_v[7] & ~em_r.res_from_mem[2]}}, byte_v};
    end
  end

  assign rf_wdata_m = (|em_r.res_from_mem) ? load_val : em_r.rf_wdata;

  assign mw_bus = {em_r.pc, rf_wdata_m, em_r.gr_we, em_r.dest, em_r.ex, em_r.ecode,
                   em_r.esubcode, em_r.csr_addr, em_r.csr_we, em_r.csr_wmask, em_r.csr_wdata};

  assign bus.M_allowin  = m_allowin;
  assign bus.MW_valid   = m_valid && ready_go && !bus.flush;
  assign bus.MW_BUS     = mw_bus;
  assign bus.MD_for_BUS = {m_valid && (|em_r.res_from_mem) && !ready_go,
                           em_r.dest & {5{m_valid && em_r.gr_we}},
                           rf_wdata_m};

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the read-data buffer is a single register, so it is reset along with the rest.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_valid   <= 1'b0;
      em_r      <= '0;
      req_m     <= 1'b0;
      state     <= S_IDLE;
      rdata_buf <= '0;
    end else begin
      if (bus.flush) begin
        m_valid <= 1'b0;
      end else if (m_allowin) begin
        m_valid <= bus.EM_valid;
        req_m   <= bus.EM_valid && bus.EM_mem_req;
        if (bus.EM_valid) begin
          em_r <= em_bus_t'(bus.EM_BUS);
        end
      end

      // data_ok outside WAIT/DROP is a protocol error and is ignored.
      case (state)
        S_IDLE: begin
          if (capture_req) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.flush) begin
            state <= data_ok ? S_IDLE : S_DROP;
          end else if (data_ok) begin
            if (bus.W_allowin) begin
              state <= capture_req ? S_WAIT : S_IDLE;
            end else begin
              rdata_buf <= bus.data_sram_rdata;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else if (bus.W_allowin) begin
            state <= capture_req ? S_WAIT : S_IDLE;
          end
        end
        S_DROP: begin
          if (data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
